p256_mod_add: RTL and testbench

// - Word-serial modular adder d = (a + b) mod p, P-256 prime, sitting beside P_256_Square in the field datapath.
// - Reads two 256-bit operands as 8x32-bit words from operand RAMs. Typically one operand is the d-RAM the squarer just wrote.
// - Writes the reduced sum as 8 words to a result RAM, then raises rdy.

---
 rtl/p256_pkg.sv | 18 +
 rtl/p256_mod_add_arith.sv | 21 ++
 rtl/p256_mod_add.sv | 119 +++++++++++
 tb/tb_p256_mod_add.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/p256_pkg.sv
// p256_pkg: shared P-256 field constants and FSM state encodings.
package p256_pkg;
    localparam logic [255:0] P_256 =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    typedef enum logic [3:0] {
        ST_LOAD_WAIT  = 4'd0,
        ST_LOAD       = 4'd1,
        ST_ADD        = 4'd2,
        ST_SUB        = 4'd3,
        ST_SEL        = 4'd4,
        ST_WRITE      = 4'd5,
        ST_WRITE_WAIT = 4'd6,
        ST_DONE       = 4'd7
    } state_e;
    function automatic logic [31:0] p_word(input logic [2:0] i);
        return P_256[32*i +: 32];
    endfunction
endpackage

// File: rtl/p256_mod_add_arith.sv
// p256_mod_add_arith: word-wide ripple adder and subtractor with carry/borrow in and out.
module Adder #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
endmodule

module Subtractor #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    // Top bit of the widened difference wraps to 1 exactly when x < y + bin.
    assign {bout, diff} = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bin};
endmodule

// File: rtl/p256_mod_add.sv
// p256_mod_add: word-serial (a + b) mod p for P-256, 8x32-bit operand RAMs in, 8 result words out.
module p256_mod_add
    import p256_pkg::*;
#(
    parameter int RD_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [31:0] a_din,
    input  logic [31:0] b_din,
    output logic        rdy,
    output logic [2:0]  a_addr,
    output logic [2:0]  b_addr,
    output logic [2:0]  d_addr,
    output logic        d_wren,
    output logic [31:0] d_dout
);
    localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [WW-1:0] WAIT_END = WW'(RD_LAT - 1);

    state_e        state_q;
    logic [WW-1:0] wait_q;
    logic [2:0]    idx_q;
    logic [31:0]   a_q [8];
    logic [31:0]   b_q [8];
    logic [31:0]   s_q [8];
    logic [31:0]   dd_q [8];
    logic          c_q, w_q, cout_q, bout_q, use_d_q;
    logic [31:0]   add_sum, sub_diff;
    logic          add_c, sub_w;

    assign b_addr = a_addr;

    Adder #(.WIDTH(32)) u_add (
        .x(a_q[idx_q]), .y(b_q[idx_q]), .cin(idx_q == 3'd0 ? 1'b0 : c_q),
        .sum(add_sum), .cout(add_c)
    );

    Subtractor #(.WIDTH(32)) u_sub (
        .x(s_q[idx_q]), .y(p_word(idx_q)), .bin(idx_q == 3'd0 ? 1'b0 : w_q),
        .diff(sub_diff), .bout(sub_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_WAIT;
            wait_q  <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            w_q     <= 1'b0;
            cout_q  <= 1'b0;
            bout_q  <= 1'b0;
            use_d_q <= 1'b0;
            rdy     <= 1'b0;
            a_addr  <= '0;
            d_addr  <= '0;
            d_wren  <= 1'b0;
            d_dout  <= '0;
            for (int i = 0; i < 8; i++) begin
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                s_q[i]  <= '0;
                dd_q[i] <= '0;
            end
        end else if (ena) begin
            case (state_q)
                ST_LOAD_WAIT: begin
                    wait_q  <= wait_q == WAIT_END ? '0 : wait_q + 1'b1;
                    state_q <= wait_q == WAIT_END ? ST_LOAD : ST_LOAD_WAIT;
                end
                ST_LOAD: begin
                    a_q[a_addr] <= a_din;
                    b_q[a_addr] <= b_din;
                    a_addr      <= a_addr + 3'd1;
                    state_q     <= a_addr == 3'd7 ? ST_ADD : ST_LOAD_WAIT;
                end
                ST_ADD: begin
                    s_q[idx_q] <= add_sum;
                    c_q        <= add_c;
                    idx_q      <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        cout_q  <= add_c;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    dd_q[idx_q] <= sub_diff;
                    w_q         <= sub_w;
                    idx_q       <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        bout_q  <= sub_w;
                        state_q <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    // 257-bit sum >= p when it carried out or p could be subtracted without borrow
                    use_d_q <= cout_q | ~bout_q;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    d_dout  <= use_d_q ? dd_q[d_addr] : s_q[d_addr];
                    d_wren  <= 1'b1;
                    state_q <= ST_WRITE_WAIT;
                end
                ST_WRITE_WAIT: begin
                    d_wren  <= 1'b0;
                    d_addr  <= d_addr == 3'd7 ? d_addr : d_addr + 3'd1;
                    state_q <= d_addr == 3'd7 ? ST_DONE : ST_WRITE;
                end
                ST_DONE: begin
                    rdy    <= 1'b1;
                    d_wren <= 1'b0;
                end
                default: state_q <= ST_LOAD_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_p256_mod_add.sv
// tb_p256_mod_add: vector table against operand/result RAM models with 3-cycle read latency.
module tb_p256_mod_add;
    localparam logic [255:0] P    = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [255:0] PM1  = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffe;
    localparam logic [255:0] PM2  = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffd;
    localparam logic [255:0] PM5  = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b1;
    logic [31:0] a_din, b_din, d_dout;
    logic        rdy, d_wren;
    logic [2:0]  a_addr, b_addr, d_addr;

    logic [31:0] a_mem [8];
    logic [31:0] b_mem [8];
    logic [31:0] d_mem [8];
    logic [31:0] pa1, pa2, pa3, pb1, pb2, pb3;
    int          wr_cnt, ord_err;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
        bit           gap;
        int           cyc;
    } vec_t;
    vec_t vt [6];

    always #5 clk = ~clk;

    p256_mod_add #(.RD_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .a_din(a_din), .b_din(b_din),
        .rdy(rdy), .a_addr(a_addr), .b_addr(b_addr), .d_addr(d_addr),
        .d_wren(d_wren), .d_dout(d_dout)
    );

    assign a_din = pa3;
    assign b_din = pb3;

    always @(posedge clk) begin
        pa1 <= a_mem[a_addr]; pa2 <= pa1; pa3 <= pa2;
        pb1 <= b_mem[b_addr]; pb2 <= pb1; pb3 <= pb2;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  = 0;
            ord_err = 0;
            for (int i = 0; i < 8; i++) d_mem[i] = 32'hdeadbeef;
        end else if (ena && d_wren) begin
            if (int'(d_addr) != wr_cnt) ord_err++;
            d_mem[d_addr] = d_dout;
            wr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mems(input logic [255:0] a, input logic [255:0] b);
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = a[32*i +: 32];
            b_mem[i] = b[32*i +: 32];
        end
    endtask

    task automatic run(input logic [255:0] a, input logic [255:0] b, input bit gap, output int got);
        int  stall;
        bit  wdone;
        stall = 0;
        wdone = 0;
        got   = -1;
        ena   = 1'b1;
        rst_n = 1'b0;
        load_mems(a, b);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                got = n;
                break;
            end
            if (stall > 0) begin
                stall--;
                if (stall == 0) ena = 1'b1;
            end else if (gap && n == 10) begin
                ena   = 1'b0;
                stall = 10;
            end else if (gap && !wdone && d_wren) begin
                ena   = 1'b0;
                stall = 5;
                wdone = 1;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [255:0] exp, input int exp_cyc, input int got);
        logic [255:0] e;
        e = exp;
        for (int i = 0; i < 8; i++) chk($sformatf("%s word%0d", tag, i), d_mem[i], e[32*i +: 32]);
        chk({tag, " rdy cycle"}, got, exp_cyc);
        chk({tag, " write count"}, wr_cnt, 8);
        chk({tag, " write order"}, ord_err, 0);
        chk({tag, " d_addr at done"}, {29'd0, d_addr}, 32'd7);
    endtask

    initial begin
        int got;
        bit hit;
        vt[0] = '{256'd0, 256'd0, 256'd0, 1'b0, 66};
        vt[1] = '{256'd1, 256'd2, 256'd3, 1'b0, 66};
        vt[2] = '{PM1, 256'd1, 256'd0, 1'b0, 66};
        vt[3] = '{PM1, PM1, PM2, 1'b0, 66};
        vt[4] = '{256'hffffffff, 256'd1, 256'h1_00000000, 1'b0, 66};
        vt[5] = '{PM1, 256'd1, 256'd0, 1'b1, 81};

        #1 rst_n = 1'b0;
        #1;
        chk("reset rdy", {31'd0, rdy}, 0);
        chk("reset a_addr", {29'd0, a_addr}, 0);
        chk("reset b_addr", {29'd0, b_addr}, 0);
        chk("reset d_addr", {29'd0, d_addr}, 0);
        chk("reset d_wren", {31'd0, d_wren}, 0);
        chk("reset d_dout", d_dout, 0);

        for (int v = 0; v < 6; v++) begin
            run(vt[v].a, vt[v].b, vt[v].gap, got);
            check_result($sformatf("vec%0d", v), vt[v].exp, vt[v].cyc, got);
        end

        run(PM5, 256'd10, 1'b0, got);
        check_result("p-5+10", 256'd5, 66, got);

        // Abort mid-write: reset must clear outputs without waiting for a clock edge.
        load_mems(PM1, 256'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = d_wren && d_addr == 3'd3;
        end
        chk("reach write word3", {31'd0, hit}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort rdy", {31'd0, rdy}, 0);
        chk("abort a_addr", {29'd0, a_addr}, 0);
        chk("abort b_addr", {29'd0, b_addr}, 0);
        chk("abort d_addr", {29'd0, d_addr}, 0);
        chk("abort d_wren", {31'd0, d_wren}, 0);
        chk("abort d_dout", d_dout, 0);
        run(256'd5, 256'd7, 1'b0, got);
        check_result("rerun 5+7", 256'd12, 66, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
